// File: rtl/ifm_in_fsm.sv
// ifm_in_fsm: ingress writer for the Ethernet RX frame FIFO pair.
// Takes the 64-bit MAC receive stream and writes each frame into the data FIFO as
// {eof, keep, data} words, plus one good/bad verdict bit per frame into the info FIFO.
// Frames that cannot fit are dropped whole at SOF or truncated (eof forced, verdict bad).
// The data and info FIFOs therefore always stay in frame lockstep.
// Optional build macro IFM_IN_STATS_EN: when defined, stat_frames/stat_drops are real
// 32-bit counters; when undefined they are tied to 0 and no counter flops exist.
module ifm_in_fsm #(
  parameter int unsigned C_MIN_LEN = 64,
  parameter int unsigned C_MAX_LEN = 1522
) (
  input  logic        sys_clk,
  input  logic        rx_reset,
  input  logic [63:0] rx_tdata,
  input  logic [7:0]  rx_tkeep,
  input  logic        rx_tvalid,
  input  logic        rx_tlast,
  input  logic        rx_tuser,
  output logic [72:0] data_fifo_wdata,
  output logic        data_fifo_wren,
  input  logic        data_fifo_afull,
  output logic        info_fifo_wdata,
  output logic        info_fifo_wren,
  input  logic        info_fifo_afull,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_drops
);

  // Frame states; encoding kept as plain constants for compatibility with older tooling.
  localparam logic [1:0] StSync = 2'd0;  // waiting for a frame boundary after reset
  localparam logic [1:0] StIdle = 2'd1;  // next valid beat is SOF
  localparam logic [1:0] StData = 2'd2;  // frame being written
  localparam logic [1:0] StDrop = 2'd3;  // discarding the rest of a frame

  // The running count saturates at 16383, so limits are compared at 14 bits.
  localparam logic [13:0] MinLen = 14'(C_MIN_LEN);
  localparam logic [13:0] MaxLen = 14'(C_MAX_LEN);

  logic [1:0]  state_q, state_d;
  logic [13:0] len_q, len_d;
  logic        data_wren_q, data_wren_d;
  logic [72:0] data_wdata_q, data_wdata_d;
  logic        info_wren_q, info_wren_d;
  logic        info_wdata_q, info_wdata_d;
  logic        sof_drop;

  logic [3:0]  keep_cnt;
  logic [14:0] len_sum;
  logic [13:0] len_acc;
  logic [13:0] sof_len;

  // Verdict for a frame closed normally on its tlast beat.
  function automatic logic frame_good(input logic [13:0] len, input logic err);
    return !err && (len >= MinLen) && (len <= MaxLen);
  endfunction

  // Byte count of the current beat and the saturating running frame length.
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      keep_cnt = keep_cnt + {3'd0, rx_tkeep[i]};
    end
    len_sum = {1'b0, len_q} + {11'd0, keep_cnt};
    len_acc = len_sum[14] ? 14'h3fff : len_sum[13:0];
    sof_len = {10'd0, keep_cnt};
  end

  // Next-state, length and FIFO write decode for the current beat.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    data_wren_d  = 1'b0;
    data_wdata_d = '0;
    info_wren_d  = 1'b0;
    info_wdata_d = 1'b0;
    sof_drop     = 1'b0;

    case (state_q)
      StSync: begin
        // Only leave once no frame can be in flight: a gap or a tlast beat.
        if (!rx_tvalid || rx_tlast) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        if (rx_tvalid) begin
          if (data_fifo_afull || info_fifo_afull) begin
            // No room for a whole frame: write nothing at all.
            sof_drop = 1'b1;
            len_d    = '0;
            if (!rx_tlast) begin
              state_d = StDrop;
            end
          end else begin
            len_d        = sof_len;
            data_wren_d  = 1'b1;
            data_wdata_d = {rx_tlast, rx_tkeep, rx_tdata};
            if (rx_tlast) begin
              info_wren_d  = 1'b1;
              info_wdata_d = frame_good(sof_len, rx_tuser);
            end else begin
              state_d = StData;
            end
          end
        end
      end

      StData: begin
        if (rx_tvalid) begin
          len_d       = len_acc;
          data_wren_d = 1'b1;
          if (rx_tlast) begin
            data_wdata_d = {1'b1, rx_tkeep, rx_tdata};
            info_wren_d  = 1'b1;
            info_wdata_d = frame_good(len_acc, rx_tuser);
            state_d      = StIdle;
          end else if (data_fifo_afull || (len_acc > MaxLen)) begin
            // Truncate: close the frame here as bad so the FIFOs stay in lockstep.
            data_wdata_d = {1'b1, rx_tkeep, rx_tdata};
            info_wren_d  = 1'b1;
            info_wdata_d = 1'b0;
            state_d      = StDrop;
          end else begin
            data_wdata_d = {1'b0, rx_tkeep, rx_tdata};
          end
        end
      end

      StDrop: begin
        if (rx_tvalid && rx_tlast) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StSync;
      end
    endcase
  end

  // State, length and registered FIFO write ports.
  always_ff @(posedge sys_clk) begin
    if (rx_reset) begin
      state_q      <= StSync;
      len_q        <= '0;
      data_wren_q  <= 1'b0;
      data_wdata_q <= '0;
      info_wren_q  <= 1'b0;
      info_wdata_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      data_wren_q  <= data_wren_d;
      data_wdata_q <= data_wdata_d;
      info_wren_q  <= info_wren_d;
      info_wdata_q <= info_wdata_d;
    end
  end

  assign data_fifo_wren  = data_wren_q;
  assign data_fifo_wdata = data_wdata_q;
  assign info_fifo_wren  = info_wren_q;
  assign info_fifo_wdata = info_wdata_q;

`ifdef IFM_IN_STATS_EN
  logic [31:0] frames_q;
  logic [31:0] drops_q;

  // Frame and SOF-drop counters; both wrap naturally at 2^32.
  always_ff @(posedge sys_clk) begin
    if (rx_reset) begin
      frames_q <= '0;
      drops_q  <= '0;
    end else begin
      if (info_wren_d) begin
        frames_q <= frames_q + 32'd1;
      end
      if (sof_drop) begin
        drops_q <= drops_q + 32'd1;
      end
    end
  end

  assign stat_frames = frames_q;
  assign stat_drops  = drops_q;
`else
  logic unused_sof_drop;
  assign unused_sof_drop = sof_drop;
  assign stat_frames     = '0;
  assign stat_drops      = '0;
`endif

endmodule

// File: tb/tb_ifm_in_fsm.sv
// Bench for ifm_in_fsm: directed frames plus randomized frames, checked by a scoreboard.
// The reference model works per frame from its byte length, error flag and back-pressure
// pattern, and pushes the expected FIFO words; a monitor pops and compares on every write.
module tb_ifm_in_fsm;
  localparam int MinLen = 64;
  localparam int MaxLen = 1522;

  logic        sys_clk = 1'b0;
  logic        rx_reset;
  logic [63:0] rx_tdata;
  logic [7:0]  rx_tkeep;
  logic        rx_tvalid;
  logic        rx_tlast;
  logic        rx_tuser;
  logic [72:0] data_fifo_wdata;
  logic        data_fifo_wren;
  logic        data_fifo_afull;
  logic        info_fifo_wdata;
  logic        info_fifo_wren;
  logic        info_fifo_afull;
  logic [31:0] stat_frames;
  logic [31:0] stat_drops;

  always #5 sys_clk = ~sys_clk;

  ifm_in_fsm #(
    .C_MIN_LEN(MinLen),
    .C_MAX_LEN(MaxLen)
  ) dut (
    .sys_clk        (sys_clk),
    .rx_reset       (rx_reset),
    .rx_tdata       (rx_tdata),
    .rx_tkeep       (rx_tkeep),
    .rx_tvalid      (rx_tvalid),
    .rx_tlast       (rx_tlast),
    .rx_tuser       (rx_tuser),
    .data_fifo_wdata(data_fifo_wdata),
    .data_fifo_wren (data_fifo_wren),
    .data_fifo_afull(data_fifo_afull),
    .info_fifo_wdata(info_fifo_wdata),
    .info_fifo_wren (info_fifo_wren),
    .info_fifo_afull(info_fifo_afull),
    .stat_frames    (stat_frames),
    .stat_drops     (stat_drops)
  );

  logic [72:0] exp_data_q[$];
  logic        exp_info_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_frames = 0;
  int          exp_drops = 0;

  function automatic void check(input string name, input logic [72:0] act,
                                input logic [72:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: every FIFO write is matched against the scoreboard.
  always @(negedge sys_clk) begin
    logic [72:0] w;
    logic        b;
    if (data_fifo_wren) begin
      if (exp_data_q.size() == 0) begin
        check("data_unexpected", data_fifo_wdata, 73'd0);
      end else begin
        w = exp_data_q.pop_front();
        check("data_word", data_fifo_wdata, w);
      end
      check("info_with_eof", 73'(info_fifo_wren), 73'(data_fifo_wdata[72]));
    end else if (info_fifo_wren) begin
      check("info_without_data", 73'(data_fifo_wren), 73'd1);
    end
    if (info_fifo_wren) begin
      if (exp_info_q.size() == 0) begin
        check("info_unexpected", 73'(info_fifo_wdata), 73'd0);
        check("info_queue_underflow", 73'd1, 73'd0);
      end else begin
        b = exp_info_q.pop_front();
        check("info_bit", 73'(info_fifo_wdata), 73'(b));
      end
    end
  end

  task automatic check_stats(input string tag);
`ifdef IFM_IN_STATS_EN
    check({tag, "_stat_frames"}, 73'(stat_frames), 73'(unsigned'(exp_frames)));
    check({tag, "_stat_drops"}, 73'(stat_drops), 73'(unsigned'(exp_drops)));
`else
    check({tag, "_stat_frames"}, 73'(stat_frames), 73'd0);
    check({tag, "_stat_drops"}, 73'(stat_drops), 73'd0);
`endif
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge sys_clk);
      #1;
      rx_tvalid       = 1'b0;
      rx_tlast        = 1'b0;
      rx_tuser        = 1'($urandom_range(0, 1));
      rx_tdata        = {$urandom, $urandom};
      rx_tkeep        = 8'($urandom);
      data_fifo_afull = 1'($urandom_range(0, 1));
      info_fifo_afull = 1'($urandom_range(0, 1));
    end
  endtask

  // Send one frame of len bytes. afull_beat = 0: no back-pressure; otherwise the chosen
  // FIFO's afull is high from that beat (1-based) to the end of the frame.
  task automatic send_frame(input int len, input bit tuser, input int afull_beat,
                            input bit afull_info, input bit gaps);
    int          n;
    int          wlast;
    int          rem;
    bit          drop;
    bit          good;
    bit          afull_on;
    logic [63:0] d;
    logic [7:0]  k;
    n    = (len + 7) / 8;
    rem  = len - 8 * (n - 1);
    drop = (afull_beat == 1);
    // Truncation point: first non-last beat that sees data afull or pushes past MaxLen.
    wlast = n;
    for (int i = 1; i < n; i++) begin
      if (wlast == n && ((!afull_info && afull_beat > 1 && i >= afull_beat) ||
                         (8 * i > MaxLen))) begin
        wlast = i;
      end
    end
    good = (wlast == n) && !tuser && (len >= MinLen) && (len <= MaxLen);
    if (drop) exp_drops++;
    else exp_frames++;

    for (int i = 1; i <= n; i++) begin
      if (gaps && i > 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      @(posedge sys_clk);
      #1;
      d               = {$urandom, $urandom};
      k               = (i == n) ? (8'hff >> (8 - rem)) : 8'hff;
      afull_on        = (afull_beat != 0) && (i >= afull_beat);
      rx_tvalid       = 1'b1;
      rx_tdata        = d;
      rx_tkeep        = k;
      rx_tlast        = (i == n);
      rx_tuser        = (i == n) ? tuser : 1'($urandom_range(0, 1));
      data_fifo_afull = afull_on && !afull_info;
      info_fifo_afull = afull_on && afull_info;
      if (!drop && i <= wlast) begin
        exp_data_q.push_back({(i == wlast), k, d});
        if (i == wlast) exp_info_q.push_back(good);
      end
    end
  endtask

  // 10-beat frame with reset held over beats 3..5: only beats 1 and 2 reach the FIFO.
  task automatic reset_mid_frame();
    logic [63:0] d;
    exp_frames = 0;
    exp_drops  = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge sys_clk);
      #1;
      d               = {$urandom, $urandom};
      rx_tvalid       = 1'b1;
      rx_tdata        = d;
      rx_tkeep        = 8'hff;
      rx_tlast        = (i == 10);
      rx_tuser        = 1'b0;
      data_fifo_afull = 1'b0;
      info_fifo_afull = 1'b0;
      rx_reset        = (i >= 3 && i <= 5);
      if (i <= 2) exp_data_q.push_back({1'b0, 8'hff, d});
    end
  endtask

  initial begin
    int len;
    int n;
    int afull_beat;
    rx_reset        = 1'b1;
    rx_tvalid       = 1'b0;
    rx_tlast        = 1'b0;
    rx_tuser        = 1'b0;
    rx_tdata        = '0;
    rx_tkeep        = '0;
    data_fifo_afull = 1'b0;
    info_fifo_afull = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_data_wren", 73'(data_fifo_wren), 73'd0);
    check("rst_data_wdata", data_fifo_wdata, 73'd0);
    check("rst_info_wren", 73'(info_fifo_wren), 73'd0);
    check("rst_info_wdata", 73'(info_fifo_wdata), 73'd0);
    check_stats("rst");
    rx_reset = 1'b0;
    idle(3);

    // Directed cases.
    send_frame(64, 1'b0, 0, 1'b0, 1'b0);   idle(3);
    send_frame(60, 1'b0, 0, 1'b0, 1'b0);   idle(2);
    send_frame(64, 1'b1, 0, 1'b0, 1'b0);   idle(2);
    send_frame(1600, 1'b0, 0, 1'b0, 1'b0);
    send_frame(64, 1'b0, 0, 1'b0, 1'b0);   idle(2);
    send_frame(64, 1'b0, 1, 1'b0, 1'b0);   idle(2);
    send_frame(160, 1'b0, 5, 1'b0, 1'b0);  idle(2);
    send_frame(64, 1'b0, 1, 1'b1, 1'b0);   idle(2);
    send_frame(64, 1'b0, 3, 1'b1, 1'b0);   idle(2);
    send_frame(1522, 1'b0, 0, 1'b0, 1'b0);
    send_frame(1523, 1'b0, 0, 1'b0, 1'b0);
    send_frame(8, 1'b0, 0, 1'b0, 1'b0);
    send_frame(64, 1'b0, 0, 1'b0, 1'b0);
    send_frame(64, 1'b0, 0, 1'b0, 1'b0);   idle(3);
    check_stats("directed");

    reset_mid_frame();
    idle(2);
    check_stats("after_reset");
    send_frame(64, 1'b0, 0, 1'b0, 1'b0);   idle(2);

    // Randomized frames.
    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(0, 9))
        0:       len = $urandom_range(1, 63);
        1:       len = $urandom_range(1523, 1700);
        2:       len = (($urandom_range(0, 1) == 0) ? 63 : 64);
        3:       len = (($urandom_range(0, 1) == 0) ? 1522 : 1523);
        default: len = $urandom_range(64, 400);
      endcase
      n = (len + 7) / 8;
      case ($urandom_range(0, 7))
        0:       afull_beat = 1;
        1:       afull_beat = $urandom_range(2, n + 1);
        default: afull_beat = 0;
      endcase
      send_frame(len, ($urandom_range(0, 5) == 0), afull_beat, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
    idle(3);

    // Bounded drain of anything still outstanding.
    for (int c = 0; c < 20 && (exp_data_q.size() != 0 || exp_info_q.size() != 0); c++) begin
      @(posedge sys_clk);
    end
    check("data_queue_drained", 73'(exp_data_q.size()), 73'd0);
    check("info_queue_drained", 73'(exp_info_q.size()), 73'd0);
    check_stats("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
